// File: rtl/adc_ser_rcvr_pkg.sv
// Shared frame format and FSM encodings for the ADC serial-config bus.
package adc_ser_rcvr_pkg;

  localparam int NCS_DEF   = 12;
  localparam int NBITS_DEF = 24;
  localparam int AW_DEF    = 5;

  // Frame layout: 8-bit address followed by 16-bit data, MSB first.
  localparam int FRAME_W  = 24;
  localparam int ADDR_MSB = 23;
  localparam int ADDR_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;
  localparam int CNT_W    = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sig_sync_edge.sv
// Two-flop synchroniser plus history flop; reports level and edges of the
// synchronised signal. All bits share the same delay so buses stay aligned.
module sig_sync_edge #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] sync,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] s1_q, s2_q, s3_q;

  // Synchroniser chain and history stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
      s3_q <= RST_VAL;
    end else begin
      // NOTE: non-blocking so each stage takes the previous stage's old value.
      s1_q <= din;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign sync = s2_q;
  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/adc_ser_rcvr.sv
// Serial-config responder: oversamples CS/SCLK/SDATA, decodes 24-bit frames,
// keeps a shadow register file and reports each frame as good or bad.
module adc_ser_rcvr
  import adc_ser_rcvr_pkg::*;
#(
  parameter int NCS   = NCS_DEF,
  parameter int NBITS = NBITS_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NCS-1:0]   CS,
  input  logic             SCLK,
  input  logic             SDATA,
  input  logic [AW-1:0]    RD_ADDR,
  output logic [15:0]      RD_DATA,
  output logic             RX_VALID,
  output logic             RX_ERR,
  output logic [7:0]       RX_ADDR,
  output logic [15:0]      RX_DATA,
  output logic [NCS-1:0]   RX_CSMASK,
  output logic             BUSY,
  output logic [15:0]      FRAME_CNT,
  output logic [7:0]       ERR_CNT
);

  localparam int SW = NCS + 2;

  // Synchronised inputs, packed as {CS, SCLK, SDATA}. Idle CS resets high so
  // reset release does not look like a frame start.
  logic [SW-1:0] sync_s2, rise_vec, fall_unused, sig_unused;
  logic [NCS-1:0] cs_s2;
  logic           sdata_s2, sclk_rise, cs_any;

  sig_sync_edge #(
    .W       (SW),
    .RST_VAL ({{NCS{1'b1}}, 2'b00})
  ) u_sync (
    .clk   (CLK),
    .rst_n (RST),
    .din   ({CS, SCLK, SDATA}),
    .sync  (sync_s2),
    .rise  (rise_vec),
    .fall  (fall_unused)
  );

  assign cs_s2      = sync_s2[SW-1:2];
  assign sdata_s2   = sync_s2[0];
  assign sclk_rise  = rise_vec[1];
  assign cs_any     = ~&cs_s2;
  assign sig_unused = {sync_s2[1], rise_vec[SW-1:2], rise_vec[0]};

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 mismatch_q, mismatch_d;
  logic [NCS-1:0]       csmask_q, csmask_d;
  logic                 busy_q, busy_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_err_q, rx_err_d;
  logic [7:0]           rx_addr_q, rx_addr_d;
  logic [15:0]          rx_data_q, rx_data_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic [7:0]           err_cnt_q, err_cnt_d;
  logic                 wr_en;
  logic                 good;
  logic [AW-1:0]        wr_idx;
  logic [15:0]          shadow_q [2**AW];
  logic [15:0]          rd_data_q;

  assign wr_idx = shift_q[ADDR_LSB +: AW];

  // Next-state and frame decode for the IDLE -> SHIFT -> DONE sequence.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    mismatch_d  = mismatch_q;
    csmask_d    = csmask_q;
    busy_d      = busy_q;
    rx_valid_d  = 1'b0;
    rx_err_d    = 1'b0;
    rx_addr_d   = rx_addr_q;
    rx_data_d   = rx_data_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    wr_en       = 1'b0;
    good        = (cnt_q == CNT_W'(NBITS)) && !mismatch_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cs_any) begin
          csmask_d   = ~cs_s2;
          shift_d    = '0;
          cnt_d      = '0;
          mismatch_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // A final SCLK edge arriving with CS release is still captured.
        if (sclk_rise) begin
          shift_d = {shift_q[FRAME_W-2:0], sdata_s2};
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
        if (cs_any && ((~cs_s2) != csmask_q)) mismatch_d = 1'b1;
        if (!cs_any) state_d = ST_DONE;
      end
      ST_DONE: begin
        rx_addr_d = shift_q[ADDR_MSB:ADDR_LSB];
        rx_data_d = shift_q[DATA_MSB:DATA_LSB];
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
        if (good) begin
          rx_valid_d  = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          wr_en       = ((shift_q[ADDR_MSB:ADDR_LSB] >> AW) == 8'd0);
        end else begin
          rx_err_d = 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, shifter and reporting registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      mismatch_q  <= 1'b0;
      csmask_q    <= '0;
      busy_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_err_q    <= 1'b0;
      rx_addr_q   <= '0;
      rx_data_q   <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      mismatch_q  <= mismatch_d;
      csmask_q    <= csmask_d;
      busy_q      <= busy_d;
      rx_valid_q  <= rx_valid_d;
      rx_err_q    <= rx_err_d;
      rx_addr_q   <= rx_addr_d;
      rx_data_q   <= rx_data_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Shadow register file, written only from DONE, plus registered read port.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      // NOTE: the shadow file is flops, so it can and must clear on reset.
      for (int i = 0; i < 2**AW; i++) shadow_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      if (wr_en) shadow_q[wr_idx] <= shift_q[DATA_MSB:DATA_LSB];
      rd_data_q <= shadow_q[RD_ADDR];
    end
  end

  assign RD_DATA   = rd_data_q;
  assign RX_VALID  = rx_valid_q;
  assign RX_ERR    = rx_err_q;
  assign RX_ADDR   = rx_addr_q;
  assign RX_DATA   = rx_data_q;
  assign RX_CSMASK = csmask_q;
  assign BUSY      = busy_q;
  assign FRAME_CNT = frame_cnt_q;
  assign ERR_CNT   = err_cnt_q;

endmodule
